serial_subtractor: RTL and testbench

- Bit-serial, LSB-first subtractor: computes a - b - bin, one bit per clock, with a start/busy/done handshake.
- Arithmetic counterpart of the combinational ripple-carry adder; trades area for latency in datapaths where subtraction is infrequent.
- Reuses one full-subtractor cell per cycle and holds the registered result until the next operation.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the sequencer state encoding and the counter-width rule.
package serial_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit counter only needs to reach W-1, so $clog2(W) bits suffice (W >= 2).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing a - b - bin over W clocks.
// Handshake: start is sampled only while idle; busy spans the W processing
// cycles; done pulses for one cycle when diff/borrow update.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int CW = cnt_width(W);

  state_t          state;
  state_t          next_state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-2:0]    d_sh;
  logic [W-1:0]    d_next;
  logic            brw;
  logic [CW-1:0]   cnt;
  logic            d_bit;
  logic            bout_bit;
  logic            last;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last   = (cnt == CW'(W - 1));
  // New difference bit enters at the MSB; after W shifts bit 0 sits at the LSB.
  assign d_next = {d_bit, d_sh};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            d_sh <= '0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_next[W-1:1];
          brw  <= bout_bit;
          if (last) begin
            // Results are only written here, so partial sums never leak out.
            cnt    <= '0;
            diff   <= d_next;
            borrow <= bout_bit;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: table vectors, random vectors with a
// reference model, and hand-written multi-cycle handshake/reset sequences.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] ediff;
    logic         eborrow;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  int           done_cyc[$];
  logic [W:0]   exp_q[$];
  logic [W:0]   last_res;

  serial_subtractor #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard: every done pulse pops one expected {borrow, diff}
  always begin
    logic [W:0] e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      chk("exp_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("diff", 32'(diff), 32'(e[W-1:0]));
        chk("borrow", 32'(borrow), 32'(e[W]));
        last_res = e;
      end
    end
  end

  // drivers
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < W + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                       input logic [W-1:0] ediff, input logic eborrow);
    int lat;
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    exp_q.push_back({eborrow, ediff});
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom_range(0, 2**W - 1));
    b = W'($urandom_range(0, 2**W - 1));
    bin = 1'($urandom_range(0, 1));
    lat = 0;
    while (done !== 1'b1 && lat < W + 10) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("hold_run", 32'({borrow, diff}), 32'(last_res));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int d0;
    int nd;
    logic [W-1:0] ra, rb;
    logic rbin;
    logic [W+1:0] full;

    vecs[0] = '{4'd9,  4'd5,  1'b0, 4'd4,  1'b0};
    vecs[1] = '{4'd5,  4'd9,  1'b0, 4'd12, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd8,  4'd1,  1'b1, 4'd6,  1'b0};
    vecs[5] = '{4'd0,  4'd1,  1'b0, 4'd15, 1'b1};
    vecs[6] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
    vecs[7] = '{4'd3,  4'd3,  1'b1, 4'd15, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors; after 5-9 check the result holds while idle
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, vecs[i].ediff, vecs[i].eborrow);
      if (i == 1) begin
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          #1;
          chk("idle_hold", 32'({borrow, diff}), 32'({1'b1, 4'd12}));
        end
      end
    end

    // random vectors against an arithmetic model
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 2**W - 1));
      rb = W'($urandom_range(0, 2**W - 1));
      rbin = 1'($urandom_range(0, 1));
      full = {2'b00, ra} - {2'b00, rb} - {{(W+1){1'b0}}, rbin};
      do_op(ra, rb, rbin, full[W-1:0], ({1'b0, ra} < ({1'b0, rb} + {{W{1'b0}}, rbin})));
    end

    // start pulsed while busy, operands changing every cycle
    d0 = done_cnt;
    @(negedge clk);
    a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 4'd4});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a = 4'd1; b = 4'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < W + 10 && done !== 1'b1; k++) begin
      a = W'($urandom_range(0, 2**W - 1));
      b = W'($urandom_range(0, 2**W - 1));
      @(posedge clk);
      #1;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("busy_ignore_dones", 32'(done_cnt - d0), 32'd1);
    chk("busy_ignore_idle", 32'(busy), 32'd0);

    // start held high: second op accepted in the done cycle
    @(negedge clk);
    a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 4'd4});
    wait_done("held_first_done");
    a = 4'd3; b = 4'd7;
    exp_q.push_back({1'b1, 4'd12});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("held_second_busy", 32'(busy), 32'd1);
    wait_done("held_second_done");
    nd = done_cyc.size();
    chk("held_spacing", 32'(done_cyc[nd-1] - done_cyc[nd-2]), 32'(W + 1));

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 4'd4});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    last_res = '0;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_borrow", 32'(borrow), 32'd0);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);
    do_op(4'd6, 4'd1, 1'b0, 4'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
